// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised matrix memory controller.
package mem_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } mem_state_e;

   localparam int DATA_W_DEF = 256;
   localparam int ELEM_W_DEF = 16;
   localparam int DEPTH_DEF  = 8;

   // Widest word the mask helper supports; callers take the low DATA_W bits.
   localparam int MASK_MAX_W = 1024;
   localparam int MASK_IDX_W = $clog2(MASK_MAX_W);

   function automatic logic [MASK_MAX_W-1:0] expand_mask(
      input logic [MASK_MAX_W-1:0] elem_mask,
      input int                    elem_w
   );
      logic [MASK_MAX_W-1:0] bits;
      int                    q;
      bits = '0;
      for (int b = 0; b < MASK_MAX_W; b++) begin
         q = b / elem_w;
         bits[b[MASK_IDX_W-1:0]] = elem_mask[q[MASK_IDX_W-1:0]];
      end
      return bits;
   endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// CLEAR/IDLE sequencer: walks the clear counter over every word, then
// reports ready until the next clear request.
module mem_clear_ctrl
   import mem_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_req_i,
   output logic              ready_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o,
   output mem_state_e        state_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   mem_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_we_o = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_we_o = 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (clear_req_i) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   assign ready_o    = (state_q == ST_IDLE);
   assign clr_addr_o = cnt_q;
   assign state_o    = state_q;

endmodule

// File: rtl/matrix_mem_ctrl.sv
// Single-port matrix memory on a shared tristate bus: masked writes, one-cycle
// registered reads with a valid strobe, sequential clear and error pulses.
module matrix_mem_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ELEM_W = ELEM_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = 4
) (
   input  logic                     clk,
   input  logic                     nReset,
   inout  wire  [DATA_W-1:0]        dataBus,
   input  logic [ADDR_W-1:0]        address,
   input  logic                     nEnable,
   input  logic                     ReadWrite,
   input  logic [DATA_W/ELEM_W-1:0] elemMask,
   input  logic                     clearReq,
   output logic                     ready,
   output logic                     rdValid,
   output logic                     addrErr,
   output logic                     collErr
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Handshake: a command is taken on a rising edge when the controller is
   // IDLE and nEnable=0; a read answers on the next cycle with rdValid=1 and
   // the word on dataBus, which is driven only while rdValid is high.

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [DATA_W-1:0] out_array_q, out_array_d;
   logic              rd_valid_q, rd_valid_d;
   logic              addr_err_q, addr_err_d;
   logic              coll_err_q, coll_err_d;

   mem_state_e        clr_state;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   logic                  cmd_valid;
   logic                  in_range;
   logic [IDX_W-1:0]      cmd_idx;
   logic [MASK_MAX_W-1:0] mask_full;
   logic [DATA_W-1:0]     bit_mask;

   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] wr_mask;

   mem_clear_ctrl #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clear (
      .clk         (clk),
      .rst_n       (nReset),
      .clear_req_i (clearReq),
      .ready_o     (ready),
      .clr_we_o    (clr_we),
      .clr_addr_o  (clr_addr),
      .state_o     (clr_state)
   );

   assign cmd_valid = (clr_state == ST_IDLE) && !nEnable;
   // One extra bit so DEPTH == 2**ADDR_W compares correctly.
   assign in_range  = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));
   assign cmd_idx   = address[IDX_W-1:0];

   always_comb begin
      mask_full = expand_mask(MASK_MAX_W'(elemMask), ELEM_W);
      bit_mask  = mask_full[DATA_W-1:0];
   end

   always_comb begin
      rd_valid_d  = 1'b0;
      out_array_d = out_array_q;
      addr_err_d  = 1'b0;
      coll_err_d  = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = cmd_idx;
      wr_data     = dataBus;
      wr_mask     = bit_mask;
      if (clr_we) begin
         wr_en   = 1'b1;
         wr_idx  = clr_addr[IDX_W-1:0];
         wr_data = '0;
         wr_mask = '1;
      end else if (cmd_valid) begin
         addr_err_d = !in_range;
         if (ReadWrite) begin
            rd_valid_d  = 1'b1;
            out_array_d = in_range ? mem_q[cmd_idx] : '0;
         end else if (rd_valid_q) begin
            // The bus is busy with our own read return, so the write data is not valid.
            coll_err_d = 1'b1;
         end else if (in_range) begin
            wr_en = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= (mem_q[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         out_array_q <= '0;
         rd_valid_q  <= 1'b0;
         addr_err_q  <= 1'b0;
         coll_err_q  <= 1'b0;
      end else begin
         out_array_q <= out_array_d;
         rd_valid_q  <= rd_valid_d;
         addr_err_q  <= addr_err_d;
         coll_err_q  <= coll_err_d;
      end
   end

   assign dataBus = rd_valid_q ? out_array_q : {DATA_W{1'bz}};
   assign rdValid = rd_valid_q;
   assign addrErr = addr_err_q;
   assign collErr = coll_err_q;

endmodule

// File: tb/tb_matrix_mem_ctrl.sv
// Directed bench for matrix_mem_ctrl: reset/clear timing, masked writes,
// range and collision errors, clear with a pending command, reset mid-clear.
module tb_matrix_mem_ctrl;

   localparam int DW = 256;
   localparam int EW = 16;
   localparam int NE = DW / EW;

   logic          clk = 1'b0;
   logic          nReset;
   logic          nEnable;
   logic          ReadWrite;
   logic          clearReq;
   logic [3:0]    address;
   logic [NE-1:0] elemMask;
   wire  [DW-1:0] dataBus;
   logic          ready, rdValid, addrErr, collErr;

   logic          tb_drv;
   logic [DW-1:0] tb_bus;
   logic [DW-1:0] model [8];
   logic [DW-1:0] pat6, p1, p2;
   logic [DW-1:0] exp_3;

   int n_vec = 0;
   int n_mis = 0;

   assign dataBus = tb_drv ? tb_bus : {DW{1'bz}};

   always #5 clk = ~clk;

   matrix_mem_ctrl dut (
      .clk       (clk),
      .nReset    (nReset),
      .dataBus   (dataBus),
      .address   (address),
      .nEnable   (nEnable),
      .ReadWrite (ReadWrite),
      .elemMask  (elemMask),
      .clearReq  (clearReq),
      .ready     (ready),
      .rdValid   (rdValid),
      .addrErr   (addrErr),
      .collErr   (collErr)
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                           input logic [NE-1:0] m);
      logic [DW-1:0] r;
      r = old_w;
      for (int e = 0; e < NE; e++)
         if (m[e]) r[e*EW +: EW] = new_w[e*EW +: EW];
      return r;
   endfunction

   task automatic idle();
      nEnable = 1'b1;
      cycle();
   endtask

   task automatic do_write(input int a, input logic [DW-1:0] d, input logic [NE-1:0] m);
      address   = 4'(a);
      ReadWrite = 1'b0;
      elemMask  = m;
      tb_bus    = d;
      tb_drv    = 1'b1;
      nEnable   = 1'b0;
      cycle();
      tb_drv  = 1'b0;
      nEnable = 1'b1;
      check($sformatf("wr%0d_addrErr", a), addrErr, (a >= 8) ? 1 : 0);
      check($sformatf("wr%0d_collErr", a), collErr, 0);
      if (a < 8) model[a] = merge(model[a], d, m);
   endtask

   task automatic do_read(input int a);
      address   = 4'(a);
      ReadWrite = 1'b1;
      nEnable   = 1'b0;
      cycle();
      nEnable = 1'b1;
      check($sformatf("rd%0d_valid", a), rdValid, 1);
      check($sformatf("rd%0d_data", a), dataBus, (a < 8) ? model[a] : '0);
      check($sformatf("rd%0d_addrErr", a), addrErr, (a >= 8) ? 1 : 0);
   endtask

   // Counts sampled cycles with ready low, starting from the current sample.
   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!ready && n < 40) begin
         n++;
         cycle();
      end
      check(tag, n, 8);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      nReset    = 1'b0;
      nEnable   = 1'b1;
      ReadWrite = 1'b1;
      clearReq  = 1'b0;
      address   = '0;
      elemMask  = '0;
      tb_drv    = 1'b0;
      tb_bus    = '0;
      for (int i = 0; i < 8; i++) model[i] = '0;
      for (int e = 0; e < NE; e++) pat6[e*EW +: EW] = 16'h1000 + 16'(e) * 16'h0111;
      p1 = {8{32'hDEAD_BEEF}};
      p2 = {8{32'h0BAD_F00D}};

      // Reset and first clear
      repeat (3) cycle();
      check("rst_ready", ready, 0);
      check("rst_rdValid", rdValid, 0);
      check("rst_addrErr", addrErr, 0);
      check("rst_collErr", collErr, 0);
      nReset = 1'b1;
      wait_ready("clr_len_boot");
      for (int a = 0; a < 8; a++) do_read(a);
      idle();
      check("rdValid_drop", rdValid, 0);

      // Masked writes, including an all-zero mask
      do_write(3, '1, 16'hFFFF);
      do_write(3, '0, 16'h0001);
      do_write(3, '1 >> 8, 16'h0000);
      do_read(3);
      exp_3 = {{240{1'b1}}, 16'h0000};
      check("mask_const", model[3], exp_3);
      idle();
      do_write(6, pat6, 16'hA5A5);
      do_write(1, p1, 16'hFFFF);
      do_write(2, p2, 16'hFFFF);
      do_read(6);
      do_read(1);
      do_read(2);
      idle();

      // Out-of-range accesses (9 aliases word 1 if the range check were lost)
      do_write(9, '1, 16'hFFFF);
      idle();
      check("oor_addrErr_clear", addrErr, 0);
      do_read(1);
      do_read(9);
      idle();

      // Collision: write right behind a read return is dropped
      do_read(1);
      address   = 4'd2;
      ReadWrite = 1'b0;
      elemMask  = 16'hFFFF;
      nEnable   = 1'b0;
      cycle();
      nEnable = 1'b1;
      check("coll_collErr", collErr, 1);
      check("coll_rdValid", rdValid, 0);
      check("coll_addrErr", addrErr, 0);
      idle();
      check("coll_collErr_clear", collErr, 0);
      do_read(2);
      idle();

      // Clear request together with a read: read completes, then clear
      do_write(5, 256'hA5, 16'hFFFF);
      address   = 4'd5;
      ReadWrite = 1'b1;
      nEnable   = 1'b0;
      clearReq  = 1'b1;
      cycle();
      nEnable  = 1'b1;
      clearReq = 1'b0;
      check("clrcmd_valid", rdValid, 1);
      check("clrcmd_data", dataBus, 256'hA5);
      wait_ready("clr_len_req");
      for (int i = 0; i < 8; i++) model[i] = '0;
      do_read(5);
      do_read(3);

      // Reset while a read return is pending
      do_read(6);
      nReset = 1'b0;
      #1;
      check("rstrd_rdValid", rdValid, 0);
      check("rstrd_ready", ready, 0);
      cycle();
      nReset = 1'b1;
      wait_ready("clr_len_rstrd");

      // Reset during cycle 4 of a clear
      do_write(4, p1, 16'hFFFF);
      clearReq = 1'b1;
      cycle();
      clearReq = 1'b0;
      repeat (3) cycle();
      nReset = 1'b0;
      #1;
      check("rstclr_ready", ready, 0);
      check("rstclr_rdValid", rdValid, 0);
      check("rstclr_addrErr", addrErr, 0);
      check("rstclr_collErr", collErr, 0);
      cycle();
      nReset = 1'b1;
      wait_ready("clr_len_rstclr");
      for (int i = 0; i < 8; i++) model[i] = '0;
      do_read(0);
      do_read(4);
      do_read(7);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
